// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bus responder.
//   spi_state_t      : frame decoder states
//   SPI_ADDR_W       : register address width (command byte minus R/W bit)
//   SPI_CMD_RW_BIT   : command byte bit selecting write (1) or read (0)
//   SPI_CMD_ADDR_MSB : top bit of the address field in the command byte
package spi_pkg;

    localparam int unsigned SPI_ADDR_W       = 7;
    localparam int unsigned SPI_CMD_RW_BIT   = 7;
    localparam int unsigned SPI_CMD_ADDR_MSB = 6;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_CMD   = 2'd1,
        SPI_WRITE = 2'd2,
        SPI_READ  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer with registered edge pulses.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   dout       : synchronized level
//   rise, fall : one-cycle pulses, STAGES+1 cycles after the pin edge
// The chain resets to 0, so a pin already low at reset release never
// produces a spurious falling edge.
module spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchronizer chain plus one history bit for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder bridging MCU frames onto a byte-wide register bus.
// Frame: command byte {rw, addr}, then data bytes; rw=1 writes, rw=0 reads.
// Ports:
//   clk_8mhz, reset : system clock, synchronous active-high reset
//   sck, fpga_cs, mosi, miso, miso_oe : SPI pins (CS active low)
//   reg_addr, reg_wdata, reg_wr, reg_rd, reg_rdata : register bus
//   busy        : frame in progress
//   frame_abort : one-cycle pulse when CS rises mid-byte
// Build option: SPI_SLAVE_ADDR_INC_EN enables per-byte address increment;
// without it the address stays at the command address (FIFO-port bursts).
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = SPI_ADDR_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_8mhz,
    input  logic              reset,
    input  logic              sck,
    input  logic              fpga_cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_abort
);

    localparam logic [1:0] ST_IDLE  = SPI_IDLE;
    localparam logic [1:0] ST_CMD   = SPI_CMD;
    localparam logic [1:0] ST_WRITE = SPI_WRITE;
    localparam logic [1:0] ST_READ  = SPI_READ;

`ifdef SPI_SLAVE_ADDR_INC_EN
    localparam logic ADDR_INC = 1'b1;
`else
    localparam logic ADDR_INC = 1'b0;
`endif

    logic                   sck_rise;
    logic                   sck_fall;
    logic                   unused_sck_lvl;
    logic                   cs_lvl;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    logic [1:0]        state, state_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [7:0]        rx, rx_next;
    logic [7:0]        tx, tx_next;
    logic              rd_pend, rd_pend_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        wdata_next;
    logic              wr_next, rd_next, abort_next, busy_next, oe_next;
    logic [7:0]        rx_byte_c;
    logic              byte_done_c;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk_8mhz),
        .reset (reset),
        .din   (sck),
        .dout  (unused_sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk_8mhz),
        .reset (reset),
        .din   (fpga_cs),
        .dout  (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // mosi needs only a level synchronizer, matched in depth to sck.
    always_ff @(posedge clk_8mhz) begin
        if (reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign rx_byte_c   = {rx[6:0], mosi_s};
    assign byte_done_c = sck_rise && (bit_cnt == 3'd7);

    // State and datapath registers.
    always_ff @(posedge clk_8mhz) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            rx          <= 8'd0;
            tx          <= 8'd0;
            rd_pend     <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= 8'd0;
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            rx          <= rx_next;
            tx          <= tx_next;
            rd_pend     <= rd_pend_next;
            reg_addr    <= addr_next;
            reg_wdata   <= wdata_next;
            reg_wr      <= wr_next;
            reg_rd      <= rd_next;
            frame_abort <= abort_next;
            busy        <= busy_next;
            miso_oe     <= oe_next;
        end
    end

    // Next-state, bit counting, byte decode and TX shifter control.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        rx_next      = rx;
        tx_next      = tx;
        rd_pend_next = reg_rd;
        addr_next    = reg_addr;
        wdata_next   = reg_wdata;
        wr_next      = 1'b0;
        rd_next      = 1'b0;
        abort_next   = 1'b0;

        if (state != ST_IDLE && sck_rise) begin
            rx_next      = rx_byte_c;
            bit_cnt_next = bit_cnt + 3'd1;
        end

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next   = ST_CMD;
                    bit_cnt_next = 3'd0;
                    rx_next      = 8'd0;
                    tx_next      = 8'd0;
                end
            end
            ST_CMD: begin
                if (byte_done_c) begin
                    addr_next = ADDR_W'(rx_byte_c[SPI_CMD_ADDR_MSB:0]);
                    if (rx_byte_c[SPI_CMD_RW_BIT]) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                        rd_next    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (byte_done_c) begin
                    wdata_next = rx_byte_c;
                    wr_next    = 1'b1;
                end
            end
            ST_READ: begin
                if (byte_done_c) begin
                    rd_next = 1'b1;
                end
                // Counter 0 marks the byte boundary: hold bit 7 for the reload.
                if (sck_fall && bit_cnt != 3'd0) begin
                    tx_next = {tx[6:0], 1'b0};
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Address advances only after the strobe that used it.
        if (reg_wr && ADDR_INC) begin
            addr_next = reg_addr + ADDR_W'(1);
        end
        if (rd_pend) begin
            tx_next = reg_rdata;
            if (ADDR_INC) begin
                addr_next = reg_addr + ADDR_W'(1);
            end
        end

        if (state != ST_IDLE && cs_rise) begin
            state_next = ST_IDLE;
            abort_next = (bit_cnt != 3'd0);
            tx_next    = 8'd0;
        end

        busy_next = (state_next != ST_IDLE) && !cs_lvl;
        oe_next   = busy_next;
    end

    assign miso = tx[7];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames from the test plan
// plus randomized frames, checked against a frame-level model.
module tb_spi_slave;

    logic       clk_8mhz = 1'b0;
    logic       reset    = 1'b1;
    logic       sck      = 1'b0;
    logic       fpga_cs  = 1'b1;
    logic       mosi     = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'd0;
    logic       busy;
    logic       frame_abort;

    spi_slave dut (
        .clk_8mhz    (clk_8mhz),
        .reset       (reset),
        .sck         (sck),
        .fpga_cs     (fpga_cs),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .frame_abort (frame_abort)
    );

    always #10 clk_8mhz = ~clk_8mhz;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register file model: read data one cycle after reg_rd.
    logic [7:0] mem [128];
    always @(posedge clk_8mhz) begin
        if (reg_rd) reg_rdata <= mem[reg_addr];
    end

    // Bus monitor.
    logic [6:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [6:0] rd_addr_q [$];
    int         abort_cycles = 0;
    always @(negedge clk_8mhz) begin
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd) rd_addr_q.push_back(reg_addr);
        if (frame_abort) abort_cycles++;
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        abort_cycles = 0;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_8mhz);
    endtask

    // Mode-0 transfer of the top nbits of b; 5-cycle half periods (100 ns).
    task automatic spi_xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = b[i];
            clks(5);
            r[i] = miso;
            sck  = 1'b1;
            clks(5);
            sck  = 1'b0;
        end
    endtask

    logic [7:0] ftx [16];
    logic [7:0] frx [16];

    task automatic run_frame(input int n);
        clear_mon();
        fpga_cs = 1'b0;
        clks(2);
        for (int i = 0; i < n; i++) begin
            spi_xfer(ftx[i], 8, frx[i]);
        end
        clks(5);
        fpga_cs = 1'b1;
        clks(10);
    endtask

    function automatic logic [6:0] exp_addr(input logic [6:0] a, input int k);
        int step;
`ifdef SPI_SLAVE_ADDR_INC_EN
        step = 1;
`else
        step = 0;
`endif
        return 7'((int'(a) + k * step) % 128);
    endfunction

    // Frame-level expectations derived from the command byte.
    task automatic check_frame(input int n, input string name);
        logic [6:0] a;
        a = ftx[0][6:0];
        check({name, " miso_cmd"}, 32'(frx[0]), 32'h0);
        check({name, " abort"}, 32'(abort_cycles), 32'd0);
        if (ftx[0][7]) begin
            check({name, " wr_cnt"}, 32'(wr_addr_q.size()), 32'(n - 1));
            check({name, " rd_cnt"}, 32'(rd_addr_q.size()), 32'd0);
            for (int i = 1; i < n; i++) begin
                if (i - 1 < wr_addr_q.size()) begin
                    check($sformatf("%s wr_addr[%0d]", name, i - 1), 32'(wr_addr_q[i-1]), 32'(exp_addr(a, i - 1)));
                    check($sformatf("%s wr_data[%0d]", name, i - 1), 32'(wr_data_q[i-1]), 32'(ftx[i]));
                end
                check($sformatf("%s miso_wr[%0d]", name, i), 32'(frx[i]), 32'h0);
            end
        end else begin
            check({name, " rd_cnt"}, 32'(rd_addr_q.size()), 32'(n));
            check({name, " wr_cnt"}, 32'(wr_addr_q.size()), 32'd0);
            for (int k = 0; k < n; k++) begin
                if (k < rd_addr_q.size())
                    check($sformatf("%s rd_addr[%0d]", name, k), 32'(rd_addr_q[k]), 32'(exp_addr(a, k)));
            end
            for (int i = 1; i < n; i++) begin
                check($sformatf("%s miso[%0d]", name, i), 32'(frx[i]), 32'(mem[exp_addr(a, i - 1)]));
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({miso, miso_oe, busy, reg_wr, reg_rd, frame_abort, reg_addr, reg_wdata});
    endfunction

    initial begin
        logic [7:0] r;
        int         n;

        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 16);

        // Reset state.
        clks(5);
        check("reset_outs", outs(), 32'h0);
        reset = 1'b0;
        clks(5);
        check("idle_outs", outs(), 32'h0);

        // Write burst 0x80 FF 00 FF 00 00 00 00 00 00.
        ftx[0] = 8'h80; ftx[1] = 8'hFF; ftx[2] = 8'h00; ftx[3] = 8'hFF;
        for (int i = 4; i < 10; i++) ftx[i] = 8'h00;
        run_frame(10);
        check_frame(10, "wburst");

        // Read burst: command 0x05, three dummy bytes.
        ftx[0] = 8'h05; ftx[1] = 8'h00; ftx[2] = 8'h00; ftx[3] = 8'h00;
        run_frame(4);
        check_frame(4, "rburst");

        // CS rises three bits into a data byte.
        clear_mon();
        fpga_cs = 1'b0;
        clks(2);
        spi_xfer(8'h83, 8, r);
        spi_xfer(8'hAA, 8, r);
        check("abort_busy_mid", 32'({busy, miso_oe}), 32'h3);
        spi_xfer(8'h5C, 3, r);
        clks(5);
        fpga_cs = 1'b1;
        clks(10);
        check("abort_wr_cnt", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("abort_wr_addr", 32'(wr_addr_q[0]), 32'h03);
            check("abort_wr_data", 32'(wr_data_q[0]), 32'hAA);
        end
        check("abort_pulse", 32'(abort_cycles), 32'd1);
        check("abort_idle", 32'({busy, miso_oe}), 32'h0);

        // Address wrap on write command 0xFF.
        ftx[0] = 8'hFF; ftx[1] = 8'h11; ftx[2] = 8'h22;
        run_frame(3);
        check_frame(3, "wrap");

        // Reset mid-byte with CS held low.
        clear_mon();
        fpga_cs = 1'b0;
        clks(2);
        spi_xfer(8'h81, 8, r);
        spi_xfer(8'h33, 3, r);
        reset = 1'b1;
        clks(1);
        check("rst_mid_outs", outs(), 32'h0);
        reset = 1'b0;
        clks(3);
        check("rst_rel_outs", outs(), 32'h0);
        spi_xfer(8'h82, 8, r);
        spi_xfer(8'h44, 8, r);
        clks(5);
        check("rst_cs_low_strobes", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'd0);
        check("rst_cs_low_busy", 32'({busy, miso_oe}), 32'h0);
        fpga_cs = 1'b1;
        clks(10);
        check("rst_no_abort", 32'(abort_cycles), 32'd0);
        ftx[0] = 8'h82; ftx[1] = 8'h55;
        run_frame(2);
        check_frame(2, "post_rst");

        // sck activity with CS high.
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            sck = 1'b1;
            clks(5);
            check($sformatf("cs_high_oe[%0d]", i), 32'({miso_oe, busy}), 32'h0);
            sck = 1'b0;
            clks(5);
        end
        check("cs_high_strobes", 32'(wr_addr_q.size() + rd_addr_q.size() + abort_cycles), 32'd0);

        // Randomized frames.
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        for (int f = 0; f < 20; f++) begin
            n = int'($urandom_range(2, 5));
            for (int i = 0; i < n; i++) ftx[i] = 8'($urandom);
            run_frame(n);
            check_frame(n, $sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder that terminates the MCU link on the FPGA side and turns SPI frames into a byte-wide register bus (`reg_*`) for the motor-control register file. It samples `sck`, `fpga_cs` and `mosi` in the `clk_8mhz` domain, decodes a command byte, and then performs auto-incrementing register writes or reads. It sits directly behind the top-level SPI pins, in front of the register file and the `m_*` motor-driver logic.

## Interface
- `ADDR_W`, 7: register address width; equals the command byte width minus the R/W bit.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `fpga_cs` and `mosi`.
- `clk_8mhz`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock from the MCU; idle low.
- `fpga_cs`  in  1  chip select, active low; a frame is one low period.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `miso_oe`  out  1  high while `fpga_cs` is low (synchronized); enables the pad tristate.
- `reg_addr`  out  ADDR_W  register address.
- `reg_wdata`  out  8  write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid exactly one cycle after `reg_rd`.
- `busy`  out  1  frame in progress.
- `frame_abort`  out  1  one-cycle pulse when CS rises mid-byte.

## Operation
- Frame format: command byte `{rw, addr[6:0]}`, then N data bytes. `rw=1` is a write, `rw=0` a read. Example: frame `0x80,0xFF,0x00,0xFF,0x00…` writes addr 0.
- States:
  - `IDLE`: on CS falling go to `CMD`.
  - `CMD`: after 8 bits, go to `WRITE` or `READ`.
  - `WRITE` / `READ`: stay until CS rises.
  - Any state: CS rising goes to `IDLE`.
- Bit counter: 3 bits, increments on each synchronized `sck` rising edge and wraps 7→0. `mosi` is sampled into the shift register on that edge.
- `WRITE`: on each completed byte, `reg_wdata` = byte, `reg_wr` pulses, then `reg_addr` increments after the strobe.
- `READ`: at command completion, and at each completed data byte:
  - `reg_rd` pulses at the current address.
  - The TX shifter loads `reg_rdata` on the next cycle, and `reg_addr` increments.
  - `miso` = TX shifter bit 7.
  - On a `sck` falling edge with bit counter ≠ 0 the shifter shifts left; with counter = 0 it does not shift.
- `miso` is 0 during `CMD`, during `WRITE` and in `IDLE`.
- Address arithmetic is modulo 2^ADDR_W: 0x7F wraps to 0x00.
- Partial byte at CS rise: discarded, no strobe, `frame_abort` pulses. A CS rise exactly on a byte boundary is a clean end with no abort.
- `sck` edges while CS is high are ignored.
- Reset: state `IDLE`; all outputs 0 (`miso`, `miso_oe`, `busy`, strobes, `reg_addr`, `reg_wdata`, `frame_abort`). Reset mid-frame abandons the frame silently. After reset releases with CS still low, the block waits in `IDLE` for a fresh CS falling edge.

## Timing
- Input latency: pin edge to internal edge pulse is `SYNC_STAGES`+1 cycles.
- `sck` high and low phases must each be ≥ 4 `clk_8mhz` cycles.
- CS setup to first `sck` rise must be ≥ 4 cycles.
- `reg_wr` is asserted `SYNC_STAGES`+2 cycles after the pin-level 8th `sck` rise of a byte.
- `reg_rd` at cycle T+1 and TX load at T+2, where T is the detected 8th rise. The load completes before the following `sck` fall, given the minimum phase above.
- `busy` and `miso_oe` follow synchronized CS with no further delay.

## Configuration
- `SPI_SLAVE_ADDR_INC_EN` defined: `reg_addr` auto-increments per data byte, as described above.
- Not defined: `reg_addr` stays at the command address for the whole frame (FIFO-port bursts). All other behaviour is unchanged.

## Structure
- Package `spi_pkg` holds:
  - the state enum `spi_state_t`
  - `SPI_ADDR_W`
  - the command bit positions `SPI_CMD_RW_BIT` and `SPI_CMD_ADDR_MSB`
- Sub-module `spi_sync`: an N-stage synchronizer plus registered rise/fall pulse outputs. It is instantiated for `sck` and `fpga_cs`. `mosi` uses the synchronizer only.

## Test plan
- Write burst of 80 bits, 0x80 FF 00 FF 00 00 00 00 00 00, `sck` 100 ns half-period, 20 ns clk → `reg_wr` ×9: addresses 0..8 with data FF,00,FF,00,00,00,00,00,00; no `frame_abort`.
- Read burst: command 0x05, three dummy bytes, register model returns addr+0x10 → `miso` bytes 0x15, 0x16, 0x17; `reg_rd` pulses at 5, 6, 7, 8.
- CS rises after 3 bits of a data byte → no `reg_wr` for that byte, `frame_abort` = 1 for one cycle, state `IDLE`.
- Write command 0xFF then 2 bytes → `reg_wr` at addr 0x7F then 0x00 (wrap); with `SPI_SLAVE_ADDR_INC_EN` undefined → both writes at 0x7F.
- `reset` pulsed mid-byte with CS still low → all outputs 0; no strobes until CS goes high then low; the next frame decodes normally.
- `sck` toggled 8 times with CS high → no strobes, `miso_oe` = 0, `busy` = 0.
